// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_seq_state_t;

   // Width of the lock-loss counter.
   localparam int LOSS_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff1;

   // Metastability filter: first flop may go metastable, second resolves it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ff1 <= 1'b0;
         q   <= 1'b0;
      end else begin
         ff1 <= d;
         q   <= ff1;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the PLL-clocked domain. A lost lock restarts the sequence.
// Optional feature: define PLL_SEQ_LOSS_COUNT_EN to build the saturating
// lock-loss counter; without it loss_count is tied to zero.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 27000,
   parameter int STABLE_CYCLES  = 2700
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lock,
   output logic              pll_reset,
   output logic              ddr_rst,
   output logic              ready,
   output logic [LOSS_W-1:0] loss_count
);

   localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

   pll_seq_state_t   state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lock_s;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (lock),
      .q   (lock_s)
   );

   // Next-state and counter logic; the counter restarts on every state change
   // and holds in RUN so it can never wrap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RESET_PLL: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (lock_s)               state_nxt = STABLE;
            else if (cnt == TO_LAST)  state_nxt = RESET_PLL;
         end
         STABLE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (!lock_s)              state_nxt = WAIT_LOCK;
            else if (cnt == STB_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (!lock_s) state_nxt = RESET_PLL;
         end
         default: state_nxt = RESET_PLL;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   // State, counter and outputs; outputs decode the next state so they
   // change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RESET_PLL;
         cnt       <= '0;
         pll_reset <= 1'b1;
         ddr_rst   <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pll_reset <= (state_nxt == RESET_PLL);
         ddr_rst   <= (state_nxt != RUN);
         ready     <= (state_nxt == RUN);
      end
   end

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic loss_inc;
   assign loss_inc = (state == RUN) && !lock_s;

   // Saturating count of lock losses seen while running.
   always_ff @(posedge clk) begin
      if (rst)                            loss_count <= '0;
      else if (loss_inc && loss_count != '1) loss_count <= loss_count + LOSS_W'(1);
   end
`else
   assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8). Stimulus queues cycle-stamped expected outputs; a monitor
// compares them on the falling edge of the matching cycle.
module tb_pll_lock_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock;
   logic       pll_reset, ddr_rst, ready;
   logic [7:0] loss_count;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (32),
      .STABLE_CYCLES  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .lock       (lock),
      .pll_reset  (pll_reset),
      .ddr_rst    (ddr_rst),
      .ready      (ready),
      .loss_count (loss_count)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic       pr;
      logic       dr;
      logic       rd;
      logic [7:0] lc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic logic [7:0] lcx(input int n);
`ifdef PLL_SEQ_LOSS_COUNT_EN
      return (n > 255) ? 8'd255 : 8'(n);
`else
      return 8'd0;
`endif
   endfunction

   task automatic expect_at(input int c, input logic pr, input logic dr,
                            input logic rd, input logic [7:0] lc, input string nm);
      exp_t e;
      e.c = c; e.pr = pr; e.dr = dr; e.rd = rd; e.lc = lc; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: pop every entry due at this cycle and compare.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].c <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_chk++;
         if (e.c < cyc) begin
            n_fail++;
            $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.c, cyc);
         end else if (pll_reset !== e.pr || ddr_rst !== e.dr || ready !== e.rd ||
                      loss_count !== e.lc) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got pll_reset=%b ddr_rst=%b ready=%b loss=%0d, expected %b %b %b %0d",
                     e.name, cyc, pll_reset, ddr_rst, ready, loss_count,
                     e.pr, e.dr, e.rd, e.lc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, l, d, r, p, w;
      rst  = 1'b1;
      lock = 1'b0;
      expect_at(2, 1, 1, 0, 0, "reset_hold_a");
      expect_at(3, 1, 1, 0, 0, "reset_hold_b");

      // Release reset, lock raised 10 cycles later.
      wait_cyc(3);
      c0  = cyc;
      rst = 1'b0;
      expect_at(c0 + 3, 1, 1, 0, 0, "s1_pulse_last");
      expect_at(c0 + 4, 0, 1, 0, 0, "s1_pulse_end");
      wait_cyc(c0 + 10);
      l    = cyc;
      lock = 1'b1;
      expect_at(l + 10, 0, 1, 0, 0, "s1_pre_ready");
      expect_at(l + 11, 0, 0, 1, 0, "s1_ready");
      wait_cyc(l + 14);

      // One-cycle lock drop in RUN.
      d    = cyc;
      lock = 1'b0;
      expect_at(d + 2,  0, 0, 1, lcx(0), "s4_still_run");
      expect_at(d + 3,  1, 1, 0, lcx(1), "s4_loss");
      expect_at(d + 6,  1, 1, 0, lcx(1), "s4_pulse_last");
      expect_at(d + 7,  0, 1, 0, lcx(1), "s4_wait");
      expect_at(d + 15, 0, 1, 0, lcx(1), "s4_pre_relock");
      expect_at(d + 16, 0, 0, 1, lcx(1), "s4_relock");
      wait_cyc(d + 1);
      lock = 1'b1;
      wait_cyc(d + 20);

      // One-cycle reset mid-RUN.
      r   = cyc;
      rst = 1'b1;
      expect_at(r + 1,  1, 1, 0, 0, "s36_reset");
      expect_at(r + 4,  1, 1, 0, 0, "s36_pulse_last");
      expect_at(r + 5,  0, 1, 0, 0, "s36_wait");
      expect_at(r + 13, 0, 1, 0, 0, "s36_pre_run");
      expect_at(r + 14, 0, 0, 1, 0, "s36_run");
      wait_cyc(r + 1);
      rst = 1'b0;
      wait_cyc(r + 18);

      // Lock held low: periodic PLL reset, timeouts do not count as losses.
      p    = cyc;
      lock = 1'b0;
      expect_at(p + 3,  1, 1, 0, lcx(1), "s2_loss");
      expect_at(p + 6,  1, 1, 0, lcx(1), "s2_p0_last");
      expect_at(p + 7,  0, 1, 0, lcx(1), "s2_p0_end");
      expect_at(p + 38, 0, 1, 0, lcx(1), "s2_pre_timeout");
      expect_at(p + 39, 1, 1, 0, lcx(1), "s2_p1_start");
      expect_at(p + 42, 1, 1, 0, lcx(1), "s2_p1_last");
      expect_at(p + 43, 0, 1, 0, lcx(1), "s2_p1_end");
      expect_at(p + 74, 0, 1, 0, lcx(1), "s2_pre_timeout2");
      expect_at(p + 75, 1, 1, 0, lcx(1), "s2_p2_start");
      w = p + 80;
      wait_cyc(w);

      // Lock glitch during STABLE: high 5, low 3, then high.
      lock = 1'b1;
      expect_at(w + 10, 0, 1, 0, lcx(1), "s3_no_run");
      expect_at(w + 18, 0, 1, 0, lcx(1), "s3_pre_run");
      expect_at(w + 19, 0, 0, 1, lcx(1), "s3_run");
      wait_cyc(w + 5);
      lock = 1'b0;
      wait_cyc(w + 8);
      lock = 1'b1;
      wait_cyc(w + 22);

      // 300 lock losses: counter saturates.
      for (int k = 1; k <= 300; k++) begin
         d    = cyc;
         lock = 1'b0;
         expect_at(d + 3,  1, 1, 0, lcx(1 + k), "s35_loss");
         expect_at(d + 16, 0, 0, 1, lcx(1 + k), "s35_relock");
         wait_cyc(d + 1);
         lock = 1'b1;
         wait_cyc(d + 17);
      end

      // Drain the scoreboard with a bounded wait.
      wait_cyc(cyc + 5);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL %s: expected check at cycle %0d never reached", e.name, e.c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
